tdm_slot_scheduler: RTL and testbench

Time-slot controller for the 4-way TDM capture/mux/XOR datapath. It arbitrates four requesters round-robin into fixed-length time slots and drives the mux selects s1/s0. It also generates the per-cycle key bit f from an LFSR, so only the slot owner's data reaches the output, and it is obfuscated. A guard interval between slots flushes the registered mux stage, so no data from one owner leaks into the next owner's slot.

---
 rtl/tdm_slot_scheduler.sv | 113 +++++++++++
 tb/tb_tdm_slot_scheduler.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/tdm_slot_scheduler.sv
// tdm_slot_scheduler: round-robin TDM slot arbiter driving mux selects and an LFSR key bit.
// Revision: 1.0
`default_nettype none

module tdm_slot_scheduler #(
  parameter int          SLOT_LEN  = 8,
  parameter int          GUARD_LEN = 2,
  parameter int          CNT_W     = 4,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] done,
  input  logic       key_en,
  output logic       s1,
  output logic       s0,
  output logic       f,
  output logic [3:0] gnt,
  output logic       slot_start,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SLOT  = 2'd1,
    GUARD = 2'd2
  } state_t;

  localparam logic [7:0]       SEED      = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
  localparam logic [CNT_W-1:0] SLOT_CNT  = CNT_W'(SLOT_LEN - 1);
  localparam logic [CNT_W-1:0] GUARD_CNT = CNT_W'(GUARD_LEN - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       rr_ptr;
  logic [7:0]       lfsr;
  logic [7:0]       lfsr_nxt;
  logic [1:0]       winner;
  logic [1:0]       idx;
  logic             start;

  // Scan from lowest to highest priority so the nearest requester after rr_ptr wins.
  always_comb begin
    winner = rr_ptr;
    idx    = '0;
    for (int i = 4; i >= 1; i--) begin
      idx = rr_ptr + 2'(i);
      if (req[idx]) winner = idx;
    end
  end

  assign start = (|req) && ((state == IDLE) || ((state == GUARD) && (cnt == '0)));

  // x^8+x^6+x^5+x^4+1, shift left with feedback into bit 0; frozen outside keyed slots.
  assign lfsr_nxt = ((state == SLOT) && key_en)
                    ? {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]}
                    : lfsr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      rr_ptr     <= 2'd3;
      lfsr       <= SEED;
      gnt        <= '0;
      s1         <= 1'b0;
      s0         <= 1'b0;
      f          <= 1'b0;
      slot_start <= 1'b0;
      busy       <= 1'b0;
    end else begin
      lfsr       <= lfsr_nxt;
      slot_start <= 1'b0;
      f          <= 1'b0;
      if (start) begin
        state      <= SLOT;
        gnt        <= 4'b0001 << winner;
        {s1, s0}   <= winner;
        slot_start <= 1'b1;
        cnt        <= SLOT_CNT;
        rr_ptr     <= winner;
        busy       <= 1'b1;
        f          <= key_en & lfsr_nxt[7];
      end else begin
        case (state)
          SLOT: begin
            if ((cnt == '0) || done[rr_ptr]) begin
              state <= GUARD;
              gnt   <= '0;
              cnt   <= GUARD_CNT;
            end else begin
              cnt <= cnt - 1'b1;
              f   <= key_en & lfsr_nxt[7];
            end
          end
          GUARD: begin
            if (cnt == '0) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tdm_slot_scheduler.sv
// tb_tdm_slot_scheduler: randomized bench against a cycle-level behavioural model.
`default_nettype none

module tb_tdm_slot_scheduler;

  localparam int SLOT_LEN  = 8;
  localparam int GUARD_LEN = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] done;
  logic       key_en;
  logic       s1, s0, f, slot_start, busy;
  logic [3:0] gnt;

  tdm_slot_scheduler #(
    .SLOT_LEN (SLOT_LEN),
    .GUARD_LEN(GUARD_LEN),
    .CNT_W    (4),
    .LFSR_SEED(8'hA5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .key_en    (key_en),
    .s1        (s1),
    .s0        (s0),
    .f         (f),
    .gnt       (gnt),
    .slot_start(slot_start),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: phase 0 idle, 1 slot, 2 guard; m_left counts cycles remaining in the phase.
  int         m_phase, m_left, m_owner, m_ptr;
  logic [7:0] m_lfsr;
  bit         m_start, m_f, prev_ss;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_left = 0; m_owner = 0; m_ptr = 3;
    m_lfsr  = 8'hA5; m_start = 0; m_f = 0; prev_ss = 0;
  endtask

  task automatic begin_slot();
    for (int k = 1; k <= 4; k++) begin
      if (req[(m_ptr + k) % 4]) begin
        m_owner = (m_ptr + k) % 4;
        break;
      end
    end
    m_ptr = m_owner; m_phase = 1; m_left = SLOT_LEN; m_start = 1;
  endtask

  task automatic model_step();
    bit adv;
    adv = (m_phase == 1) && key_en;
    m_start = 0;
    case (m_phase)
      0: if (req != 0) begin_slot();
      1: if (m_left == 1 || done[m_owner]) begin m_phase = 2; m_left = GUARD_LEN; end
         else m_left--;
      default: if (m_left == 1) begin
                 if (req != 0) begin_slot(); else m_phase = 0;
               end else m_left--;
    endcase
    if (adv) m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
    m_f = (m_phase == 1) && key_en && m_lfsr[7];
  endtask

  task automatic compare();
    logic [3:0] eg;
    eg = (m_phase == 1) ? 4'(1 << m_owner) : 4'd0;
    chk("gnt", 8'(gnt), 8'(eg));
    chk("sel", 8'({s1, s0}), 8'(m_owner));
    chk("busy", 8'(busy), 8'(m_phase != 0));
    chk("slot_start", 8'(slot_start), 8'(m_start));
    chk("f", 8'(f), 8'(m_f));
    chk("ss_twice", 8'(slot_start & prev_ss), 8'd0);
    prev_ss = slot_start;
  endtask

  task automatic cycle(input logic [3:0] r, input logic [3:0] d, input logic k);
    req = r; done = d; key_en = k;
    @(posedge clk);
    if (rst) model_step(); else model_reset();
    #1;
    compare();
  endtask

  task automatic async_reset();
    #2 rst = 1'b0;
    #1;
    chk("arst_gnt", 8'(gnt), 8'd0);
    chk("arst_sel", 8'({s1, s0}), 8'd0);
    chk("arst_f", 8'(f), 8'd0);
    chk("arst_busy", 8'(busy), 8'd0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    int n;
    rst = 1'b0; req = '0; done = '0; key_en = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt", 8'(gnt), 8'd0);
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_ss", 8'(slot_start), 8'd0);
    rst = 1'b1;

    // Single requester: first slot, seed-derived key bit, re-grant after guard.
    cycle(4'b0001, 4'b0000, 1'b1);
    chk("first_gnt", 8'(gnt), 8'h01);
    chk("first_f", 8'(f), 8'd1);
    repeat (22) cycle(4'b0001, 4'b0000, 1'b1);

    repeat (50) cycle(4'b1111, 4'b0000, 1'b1);

    // Owner release via done, plus non-owner done pulses.
    for (int i = 0; i < 40; i++)
      cycle(4'b0100, ($urandom % 5 == 0) ? 4'b0100 : (($urandom % 3 == 0) ? 4'b0010 : 4'b0000), 1'b1);

    repeat (30) cycle(4'b1111, 4'b0000, 1'b0);

    // Reset during the 5th cycle of a slot, then a fresh request from requester 3.
    n = 0;
    while (!(m_phase == 1 && m_left == SLOT_LEN - 4) && n < 40) begin
      cycle(4'b1111, 4'b0000, 1'b1);
      n++;
    end
    chk("find_slot5", 8'(n < 40), 8'd1);
    async_reset();
    cycle(4'b1000, 4'b0000, 1'b1);
    chk("post_rst_gnt", 8'(gnt), 8'h08);
    chk("post_rst_f", 8'(f), 8'd1);
    repeat (3) cycle(4'b0000, 4'b0000, 1'b1);
    repeat (20) cycle(4'b0000, 4'b0000, 1'b1);
    chk("idle_sel", 8'({s1, s0}), 8'd3);
    chk("idle_busy", 8'(busy), 8'd0);

    for (int i = 0; i < 1500; i++) begin
      logic [3:0] r;
      r = 4'($urandom);
      if ($urandom % 4 == 0) r = 4'd0;
      cycle(r, ($urandom % 10 == 0) ? 4'($urandom) : 4'd0, ($urandom % 8) != 0);
      if ($urandom % 300 == 0) async_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
